// File: rtl/img_pkg.sv
// Image geometry shared by the morphology pipeline, and the state encoding of the raster streamer.
package img_pkg;

  localparam int IMG_WIDTH     = 256;
  localparam int IMG_HEIGHT    = 128;
  localparam int IMG_ADDR_W    = 15;
  localparam int IMG_FLUSH_LEN = 2 * IMG_WIDTH + 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_STREAM,
    ST_FLUSH,
    ST_DONE
  } streamer_state_t;

endpackage

// File: rtl/pixel_streamer_if.sv
// Serial pixel stream with frame/line markers. Transfer happens on pixel_valid && ready;
// the master side holds every field stable while ready is low.
interface pixel_streamer_if
  import img_pkg::*;
#(
  parameter int ADDR_W = IMG_ADDR_W
);

  logic              pixel;
  logic              pixel_valid;
  logic              ready;
  logic [ADDR_W-1:0] pixel_addr;
  logic              sof;
  logic              sol;
  logic              eof;
  logic              flushing;

  modport master (
    output pixel, pixel_valid, pixel_addr, sof, sol, eof, flushing,
    input  ready
  );

  modport slave (
    input  pixel, pixel_valid, pixel_addr, sof, sol, eof, flushing,
    output ready
  );

endinterface

// File: rtl/raster_counter.sv
// Frame address register with clear/increment and the position flags of the current address.
// Zero latency on the flags; the address only moves when inc is asserted.
module raster_counter
  import img_pkg::*;
#(
  parameter int WIDTH  = IMG_WIDTH,
  parameter int HEIGHT = IMG_HEIGHT,
  parameter int ADDR_W = IMG_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] next_addr,
  output logic              at_first,
  output logic              at_col0,
  output logic              at_last
);

  localparam int                COL_W     = $clog2(WIDTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr <= '0;
    end else if (clear) begin
      addr <= '0;
    end else if (inc) begin
      addr <= next_addr;
    end
  end

  assign next_addr = addr + ADDR_W'(1);
  assign at_first  = (addr == '0);
  // WIDTH is a power of two, so the column is just the low address bits.
  assign at_col0   = (addr[COL_W-1:0] == '0);
  assign at_last   = (addr == LAST_ADDR);

endmodule

// File: rtl/pixel_streamer.sv
// Raster-scan 1-bit frame source: 2-clock start-to-first-pixel latency, outputs held while ready is low.
// Define PIXEL_STREAMER_FLUSH_EN to append FLUSH_LEN zero pixels after the eof pixel.
module pixel_streamer
  import img_pkg::*;
#(
  parameter int WIDTH  = IMG_WIDTH,
  parameter int HEIGHT = IMG_HEIGHT,
  parameter int ADDR_W = IMG_ADDR_W
`ifdef PIXEL_STREAMER_FLUSH_EN
  ,
  parameter int FLUSH_LEN = IMG_FLUSH_LEN
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_data,
  output logic              busy,
  output logic              done,
  pixel_streamer_if.master  px
);

  streamer_state_t   state;
  streamer_state_t   next_state;
  logic              load;
  logic              cnt_clear;
  logic              cnt_inc;
  logic [ADDR_W-1:0] data_addr;
  logic [ADDR_W-1:0] next_addr;
  logic              at_first;
  logic              at_col0;
  logic              at_last;

  raster_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .ADDR_W (ADDR_W)
  ) u_counter (
    .clock     (clock),
    .reset     (reset),
    .clear     (cnt_clear),
    .inc       (cnt_inc),
    .addr      (data_addr),
    .next_addr (next_addr),
    .at_first  (at_first),
    .at_col0   (at_col0),
    .at_last   (at_last)
  );

`ifdef PIXEL_STREAMER_FLUSH_EN
  localparam int FCNT_W = $clog2(FLUSH_LEN + 1);

  logic [FCNT_W-1:0] flush_cnt;
  logic              flush_last;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flush_cnt <= '0;
    end else if (state != ST_FLUSH) begin
      flush_cnt <= '0;
    end else if (load) begin
      flush_cnt <= flush_cnt + FCNT_W'(1);
    end
  end

  assign flush_last = (flush_cnt == FCNT_W'(FLUSH_LEN - 1));
`else
  assign px.flushing = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (start) next_state = ST_PRIME;
      ST_PRIME:  next_state = ST_STREAM;
      ST_STREAM: begin
        if (load && at_last) begin
`ifdef PIXEL_STREAMER_FLUSH_EN
          next_state = ST_FLUSH;
`else
          next_state = ST_DONE;
`endif
        end
      end
`ifdef PIXEL_STREAMER_FLUSH_EN
      ST_FLUSH:  if (load && flush_last) next_state = ST_DONE;
`endif
      ST_DONE:   if (!px.pixel_valid) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    load      = 1'b0;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    mem_addr  = '0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      ST_IDLE:   busy = 1'b0;
      ST_PRIME:  cnt_clear = 1'b1;
      ST_STREAM: begin
        load    = !px.pixel_valid || px.ready;
        cnt_inc = load;
        // Re-presenting the same address on a stall keeps mem_data stable.
        mem_addr = load ? next_addr : data_addr;
      end
`ifdef PIXEL_STREAMER_FLUSH_EN
      ST_FLUSH:  load = !px.pixel_valid || px.ready;
`endif
      ST_DONE:   done = !px.pixel_valid;
      default:   busy = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      px.pixel       <= 1'b0;
      px.pixel_valid <= 1'b0;
      px.pixel_addr  <= '0;
      px.sof         <= 1'b0;
      px.sol         <= 1'b0;
      px.eof         <= 1'b0;
`ifdef PIXEL_STREAMER_FLUSH_EN
      px.flushing    <= 1'b0;
`endif
    end else if (state == ST_STREAM && load) begin
      px.pixel       <= mem_data;
      px.pixel_valid <= 1'b1;
      px.pixel_addr  <= data_addr;
      px.sof         <= at_first;
      px.sol         <= at_col0;
      px.eof         <= at_last;
`ifdef PIXEL_STREAMER_FLUSH_EN
      px.flushing    <= 1'b0;
    end else if (state == ST_FLUSH && load) begin
      // pixel_addr is left at the last frame address for the whole tail.
      px.pixel       <= 1'b0;
      px.pixel_valid <= 1'b1;
      px.sof         <= 1'b0;
      px.sol         <= 1'b0;
      px.eof         <= 1'b0;
      px.flushing    <= 1'b1;
`endif
    end else if (state == ST_DONE && px.ready) begin
      px.pixel_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pixel_streamer.sv
// Directed bench for pixel_streamer on a reduced 16x8 frame with a synchronous-read RAM model.
`timescale 1ns/1ps
module tb_pixel_streamer;

  localparam int W  = 16;
  localparam int H  = 8;
  localparam int AW = 7;
  localparam int N  = W * H;
`ifdef PIXEL_STREAMER_FLUSH_EN
  localparam int FL = 2 * W + 2;
`else
  localparam int FL = 0;
`endif
  localparam int TOTAL  = N + FL;
  localparam int BUDGET = 4 * TOTAL + 50;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          mem_data;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic          mem [N];

  int checks   = 0;
  int failures = 0;

  pixel_streamer_if #(.ADDR_W(AW)) px ();

  pixel_streamer #(
    .WIDTH  (W),
    .HEIGHT (H),
    .ADDR_W (AW)
`ifdef PIXEL_STREAMER_FLUSH_EN
    ,
    .FLUSH_LEN (FL)
`endif
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .busy     (busy),
    .done     (done),
    .px       (px)
  );

  always #5 clock = ~clock;

  always @(posedge clock) mem_data <= mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic fill(input int kind);
    for (int a = 0; a < N; a++) begin
      mem[a] = (kind == 0) ? 1'(a[0] ^ a[4]) : 1'b1;
    end
  endtask

  task automatic check_cleared();
    check("clr_valid", 32'(px.pixel_valid), 0);
    check("clr_pixel", 32'(px.pixel), 0);
    check("clr_addr", 32'(px.pixel_addr), 0);
    check("clr_sof", 32'(px.sof), 0);
    check("clr_sol", 32'(px.sol), 0);
    check("clr_eof", 32'(px.eof), 0);
    check("clr_flushing", 32'(px.flushing), 0);
    check("clr_busy", 32'(busy), 0);
    check("clr_done", 32'(done), 0);
    check("clr_mem_addr", 32'(mem_addr), 0);
  endtask

  // Called at a negedge with the DUT idle. reset_at >= 0 aborts the frame with reset at that transfer.
  task automatic run_frame(input bit rand_rdy, input bit glitch, input int reset_at);
    int xfers = 0;
    int cyc = 0;
    int stalls = 0;
    int first_v = -1;
    int n_sof = 0;
    int n_sol = 0;
    int n_eof = 0;
    int ea;
    bit prev_stall = 1'b0;
    bit aborted = 1'b0;
    logic [AW+5:0] now;
    logic [AW+5:0] held = '0;

    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("start_busy", 32'(busy), 1);
    check("start_valid", 32'(px.pixel_valid), 0);

    while (xfers < TOTAL && cyc < BUDGET) begin
      now = {px.pixel_valid, px.pixel, px.sof, px.sol, px.eof, px.flushing, px.pixel_addr};
      if (prev_stall) check("stall_hold", 32'(now), 32'(held));
      if (px.pixel_valid && first_v < 0) first_v = cyc;
      start = glitch && (cyc == 40);
      if (reset_at >= 0 && xfers == reset_at) begin
        reset = 1'b1;
        #1;
        check_cleared();
        aborted = 1'b1;
        break;
      end
      px.ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (px.pixel_valid && px.ready) begin
        ea = (xfers < N) ? xfers : N - 1;
        check("addr", 32'(px.pixel_addr), ea);
        check("pixel", 32'(px.pixel), (xfers < N) ? 32'(mem[ea]) : 0);
        check("sof", 32'(px.sof), 32'(xfers == 0));
        check("sol", 32'(px.sol), 32'(xfers < N && xfers % W == 0));
        check("eof", 32'(px.eof), 32'(xfers == N - 1));
        check("flushing", 32'(px.flushing), 32'(xfers >= N));
        check("busy_run", 32'(busy), 1);
        check("done_early", 32'(done), 0);
        n_sof += int'(px.sof);
        n_sol += int'(px.sol);
        n_eof += int'(px.eof);
        xfers++;
      end
      prev_stall = px.pixel_valid && !px.ready;
      if (prev_stall) stalls++;
      held = now;
      @(negedge clock);
      cyc++;
    end

    if (aborted) begin
      @(negedge clock);
      check("rst_no_done", 32'(done), 0);
      reset = 1'b0;
      @(negedge clock);
      check("post_rst_busy", 32'(busy), 0);
      check("post_rst_done", 32'(done), 0);
    end else begin
      check("xfer_count", xfers, TOTAL);
      check("first_valid", first_v, 2);
      check("cycles", cyc, TOTAL + 2 + stalls);
      check("done_pulse", 32'(done), 1);
      check("done_busy", 32'(busy), 1);
      check("done_valid", 32'(px.pixel_valid), 0);
      check("sof_count", n_sof, 1);
      check("sol_count", n_sol, H);
      check("eof_count", n_eof, 1);
      start = glitch;
      @(negedge clock);
      start = 1'b0;
      check("after_done", 32'(done), 0);
      check("after_busy", 32'(busy), 0);
      @(negedge clock);
      check("idle_busy", 32'(busy), 0);
      check("idle_valid", 32'(px.pixel_valid), 0);
    end
  endtask

  initial begin
    px.ready = 1'b0;
    fill(0);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check_cleared();
    reset = 1'b0;
    @(negedge clock);

    run_frame(1'b0, 1'b0, -1);
    run_frame(1'b1, 1'b0, -1);
    fill(1);
    run_frame(1'b0, 1'b1, -1);
    fill(0);
    run_frame(1'b1, 1'b0, 50);
    run_frame(1'b0, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
